// File: rtl/tc_nc_reader_if.sv
// Request/result and TC RAM bus bundle for the nC reader.
// slave = reader side, master = CAVLC front-end plus the TC RAMs.
interface tc_nc_reader_if;
  logic        nc_req;
  logic [1:0]  comp;
  logic [3:0]  blk;
  logic [7:0]  mb_num_h;
  logic [7:0]  mb_num_v;
  logic        mb_start;
  logic        TC_wr_n;
  logic [5:0]  TC_A_wr_addr;
  logic [4:0]  TC_din;
  logic        TC_A_rd_n;
  logic [5:0]  TC_A_rd_addr;
  logic [4:0]  TC_A_dout;
  logic        TC_B_rd_n;
  logic [12:0] TC_B_rd_addr;
  logic [4:0]  TC_B_dout;
  logic        busy;
  logic        nc_valid;
  logic [4:0]  nc;

  modport slave (
    input  nc_req, comp, blk, mb_num_h, mb_num_v, mb_start,
    input  TC_wr_n, TC_A_wr_addr, TC_din, TC_A_dout, TC_B_dout,
    output TC_A_rd_n, TC_A_rd_addr, TC_B_rd_n, TC_B_rd_addr,
    output busy, nc_valid, nc
  );

  modport master (
    output nc_req, comp, blk, mb_num_h, mb_num_v, mb_start,
    output TC_wr_n, TC_A_wr_addr, TC_din, TC_A_dout, TC_B_dout,
    input  TC_A_rd_n, TC_A_rd_addr, TC_B_rd_n, TC_B_rd_addr,
    input  busy, nc_valid, nc
  );
endinterface

// File: rtl/tc_nc_reader.sv
// Fetches TotalCoeff of the left (A) and above (B) neighbours of a 4x4 block
// and returns nC; fixed four-cycle latency from request to result strobe.
module tc_nc_reader (
  input logic           clk,
  input logic           reset_n,
  tc_nc_reader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  comp_r, x_r, y_r;
  logic [7:0]  mbh_r, mbv_r;
  logic [4:0]  na_r;
  logic [4:0]  cur_r  [0:11];
  logic [4:0]  left_r [0:11];

  function automatic logic [5:0] comp_base(input logic [1:0] c);
    case (c)
      2'd1:    return 6'd18;
      2'd2:    return 6'd34;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [3:0] blk_of(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

  logic [1:0] comp_in_s, x_in_s, y_in_s;
  logic [5:0] a_addr_in_s;

  // Decode of the request being accepted; the A strobe goes out on the accept edge
  always_comb begin
    comp_in_s   = (bus.comp == 2'd3) ? 2'd0 : bus.comp;
    x_in_s      = {bus.blk[2], bus.blk[0]};
    y_in_s      = {bus.blk[3], bus.blk[1]};
    a_addr_in_s = comp_base(comp_in_s) + {2'b00, blk_of(x_in_s - 2'd1, y_in_s)};
  end

  logic       a_avail_s, b_avail_s;
  logic [5:0] b_a_addr_s, b_low_s;
  logic [4:0] na_s, nb_s, nc_s;

  // Neighbour availability, B addresses and nC arithmetic for the latched request
  always_comb begin
    a_avail_s  = (x_r != 2'd0) || (mbh_r != 8'd0);
    b_avail_s  = (y_r != 2'd0) || (mbv_r != 8'd0);
    b_a_addr_s = comp_base(comp_r) + {2'b00, blk_of(x_r, y_r - 2'd1)};
    b_low_s    = comp_base(comp_r) + {2'b00, blk_of(x_r, 2'd3)};
    if (!a_avail_s)           na_s = 5'd0;
    else if (x_r == 2'd0)     na_s = left_r[{comp_r, y_r}];
    else                      na_s = bus.TC_A_dout;
    if (!b_avail_s)           nb_s = 5'd0;
    else if (y_r != 2'd0)     nb_s = bus.TC_A_dout;
    else                      nb_s = bus.TC_B_dout;
    if (a_avail_s && b_avail_s) nc_s = 5'(({1'b0, na_r} + {1'b0, nb_s} + 6'd1) >> 1);
    else if (a_avail_s)         nc_s = na_r;
    else if (b_avail_s)         nc_s = nb_s;
    else                        nc_s = 5'd0;
  end

  logic        a_rd_n_s, b_rd_n_s, valid_s, latch_s, cap_a_s;
  logic [5:0]  a_addr_s;
  logic [12:0] b_addr_s;

  // Next state plus next values of the registered strobes
  always_comb begin
    state_s  = state_r;
    a_rd_n_s = 1'b1;
    a_addr_s = 6'd0;
    b_rd_n_s = 1'b1;
    b_addr_s = 13'd0;
    valid_s  = 1'b0;
    latch_s  = 1'b0;
    cap_a_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.nc_req) begin
          state_s = RDA;
          latch_s = 1'b1;
          if (x_in_s != 2'd0) begin
            a_rd_n_s = 1'b0;
            a_addr_s = a_addr_in_s;
          end else begin
            a_rd_n_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RDA: begin
        state_s = RDB;
        if (b_avail_s && (y_r != 2'd0)) begin
          a_rd_n_s = 1'b0;
          a_addr_s = b_a_addr_s;
        end else if (b_avail_s) begin
          b_rd_n_s = 1'b0;
          b_addr_s = {mbh_r[6:0], b_low_s};
        end else begin
          b_rd_n_s = 1'b1;
        end
      end
      RDB: begin
        state_s = CAP;
        cap_a_s = 1'b1;
      end
      CAP: begin
        state_s = OUT;
        valid_s = 1'b1;
      end
      OUT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request, captured nA and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      comp_r           <= 2'd0;
      x_r              <= 2'd0;
      y_r              <= 2'd0;
      mbh_r            <= 8'd0;
      mbv_r            <= 8'd0;
      na_r             <= 5'd0;
      bus.TC_A_rd_n    <= 1'b1;
      bus.TC_A_rd_addr <= 6'd0;
      bus.TC_B_rd_n    <= 1'b1;
      bus.TC_B_rd_addr <= 13'd0;
      bus.busy         <= 1'b0;
      bus.nc_valid     <= 1'b0;
      bus.nc           <= 5'd0;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        comp_r <= comp_in_s;
        x_r    <= x_in_s;
        y_r    <= y_in_s;
        mbh_r  <= bus.mb_num_h;
        mbv_r  <= bus.mb_num_v;
      end
      if (cap_a_s) na_r <= na_s;
      bus.TC_A_rd_n    <= a_rd_n_s;
      bus.TC_A_rd_addr <= a_addr_s;
      bus.TC_B_rd_n    <= b_rd_n_s;
      bus.TC_B_rd_addr <= b_addr_s;
      bus.busy         <= (state_s != IDLE);
      bus.nc_valid     <= valid_s;
      if (valid_s) bus.nc <= nc_s;
    end
  end

  logic       snoop_hit_s;
  logic [1:0] snoop_comp_s;
  logic [3:0] snoop_blk_s, snoop_idx_s;

  // Snooped write: only right-column (x=3) blocks of a valid component are kept
  always_comb begin
    snoop_comp_s = 2'd0;
    snoop_blk_s  = 4'd0;
    snoop_hit_s  = 1'b0;
    if (bus.TC_A_wr_addr < 6'd16) begin
      snoop_blk_s = bus.TC_A_wr_addr[3:0];
      snoop_hit_s = 1'b1;
    end else if ((bus.TC_A_wr_addr >= 6'd18) && (bus.TC_A_wr_addr <= 6'd33)) begin
      snoop_comp_s = 2'd1;
      snoop_blk_s  = 4'(bus.TC_A_wr_addr - 6'd18);
      snoop_hit_s  = 1'b1;
    end else if ((bus.TC_A_wr_addr >= 6'd34) && (bus.TC_A_wr_addr <= 6'd49)) begin
      snoop_comp_s = 2'd2;
      snoop_blk_s  = 4'(bus.TC_A_wr_addr - 6'd34);
      snoop_hit_s  = 1'b1;
    end else begin
      snoop_hit_s = 1'b0;
    end
    snoop_hit_s = snoop_hit_s && !bus.TC_wr_n && snoop_blk_s[2] && snoop_blk_s[0];
    snoop_idx_s = {snoop_comp_s, snoop_blk_s[3], snoop_blk_s[1]};
  end

  // Column stores; on mb_start left takes the pre-write contents of cur
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 12; i++) begin
        cur_r[i]  <= 5'd0;
        left_r[i] <= 5'd0;
      end
    end else begin
      if (bus.mb_start) begin
        for (int i = 0; i < 12; i++) left_r[i] <= cur_r[i];
      end
      if (snoop_hit_s) cur_r[snoop_idx_s] <= bus.TC_din;
    end
  end

endmodule
